// File: rtl/call_frame_stack.sv
// LIFO of 240-bit caller-saved register frames for call/return, with a pop-restore sequencer.
// Define CALL_FRAME_STACK_ERR_EN to build the sticky overflow/underflow flags and clr_err handling.
module call_frame_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 240
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             frame_in,
  input  logic                         clr_err,
  output logic [WIDTH-1:0]             frame_out,
  output logic                         restore,
  output logic                         busy,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err_overflow,
  output logic                         err_underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RESTORE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     sp_q, sp_d;
  logic [WIDTH-1:0]  frame_q, frame_d;
  logic              restore_q, restore_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic idle, push_req, pop_req, push_ok, pop_ok, ovf_ev, unf_ev;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == DEPTH_C);

  // Simultaneous push and pop is treated as no request at all, so neither can fault.
  always_comb begin
    idle     = (state_q == IDLE);
    push_req = idle && push && !pop;
    pop_req  = idle && pop && !push;
    push_ok  = push_req && !full;
    pop_ok   = pop_req && !empty;
    ovf_ev   = push_req && full;
    unf_ev   = pop_req && empty;

    sp_d = sp_q;
    if (push_ok) begin
      sp_d = sp_q + ONE_C;
    end else if (pop_ok) begin
      sp_d = sp_q - ONE_C;
    end

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pop_ok ? LOAD : IDLE;
      LOAD:    state_d = RESTORE;
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    frame_d = frame_q;
    if (state_q == LOAD) begin
      frame_d = mem[sp_q[AW-1:0]];
    end

    restore_d = (state_q == RESTORE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sp_q      <= '0;
      frame_q   <= '0;
      restore_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      frame_q   <= frame_d;
      restore_q <= restore_d;
      busy_q    <= busy_d;
    end
  end

  // Frame storage is deliberately left unreset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[sp_q[AW-1:0]] <= frame_in;
    end
  end

  assign frame_out = frame_q;
  assign restore   = restore_q;
  assign busy      = busy_q;
  assign count     = sp_q;

`ifdef CALL_FRAME_STACK_ERR_EN
  logic err_ovf_q, err_unf_q;

  // A new fault in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      if (ovf_ev) begin
        err_ovf_q <= 1'b1;
      end else if (clr_err) begin
        err_ovf_q <= 1'b0;
      end
      if (unf_ev) begin
        err_unf_q <= 1'b1;
      end else if (clr_err) begin
        err_unf_q <= 1'b0;
      end
    end
  end

  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
`else
  logic unused_err;
  assign unused_err    = clr_err | ovf_ev | unf_ev;
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_call_frame_stack.sv
// Directed testbench for call_frame_stack: push/pop ordering, pop timing, overflow/underflow, busy, reset.
// Error-flag expectations follow CALL_FRAME_STACK_ERR_EN as given to the build.
module tb_call_frame_stack;

  localparam int DEPTH = 16;
  localparam int WIDTH = 240;

`ifdef CALL_FRAME_STACK_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic             clock;
  logic             resetN;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] frameIn;
  logic             clrErr;
  logic [WIDTH-1:0] frameOut;
  logic             restore;
  logic             busy;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             errOverflow;
  logic             errUnderflow;

  int compared   = 0;
  int mismatched = 0;

  call_frame_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clock),
    .reset_n      (resetN),
    .push         (push),
    .pop          (pop),
    .frame_in     (frameIn),
    .clr_err      (clrErr),
    .frame_out    (frameOut),
    .restore      (restore),
    .busy         (busy),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .err_overflow (errOverflow),
    .err_underflow(errUnderflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] mkFrame(input int k);
    logic [15:0] w;
    w = 16'h1000 + 16'(k) * 16'h0111;
    return {15{w}};
  endfunction

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic q, input logic [WIDTH-1:0] f, input logic c);
    push    = p;
    pop     = q;
    frameIn = f;
    clrErr  = c;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [WIDTH-1:0] f0, f1;

  initial begin
    f0 = {15{16'h0101}};
    f1 = {15{16'h0202}};
    resetN = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    #3;
    checkOutput("reset frame_out", frameOut, '0);
    checkOutput("reset restore", restore, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset empty", empty, 1);
    checkOutput("reset full", full, 0);
    checkOutput("reset count", count, 0);
    checkOutput("reset err_overflow", errOverflow, 0);
    checkOutput("reset err_underflow", errUnderflow, 0);
    #4 resetN = 1'b1;
    tick();

    $display("[TB] basic push/pop");
    applyStimulus(1'b1, 1'b0, f0, 1'b0);
    tick();
    checkOutput("count after first push", count, 1);
    applyStimulus(1'b1, 1'b0, f1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("count after two pushes", count, 2);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("pop1 busy at N", busy, 1);
    checkOutput("pop1 count at N", count, 1);
    checkOutput("pop1 restore at N", restore, 0);
    tick();
    checkOutput("pop1 frame_out at N+1", frameOut, f1);
    checkOutput("pop1 restore at N+1", restore, 0);
    checkOutput("pop1 busy at N+1", busy, 1);
    tick();
    checkOutput("pop1 restore at N+2", restore, 1);
    checkOutput("pop1 busy at N+2", busy, 0);
    checkOutput("pop1 frame_out at N+2", frameOut, f1);
    tick();
    checkOutput("pop1 restore at N+3", restore, 0);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("pop2 count", count, 0);
    checkOutput("pop2 empty", empty, 1);
    tick();
    checkOutput("pop2 frame_out", frameOut, f0);
    tick();
    checkOutput("pop2 restore", restore, 1);
    tick();

    $display("[TB] fill and overflow");
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, 1'b0, mkFrame(k), 1'b0);
      tick();
    end
    checkOutput("fill full", full, 1);
    checkOutput("fill count", count, 16);
    checkOutput("fill err_overflow before", errOverflow, 0);
    applyStimulus(1'b1, 1'b0, mkFrame(DEPTH), 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("overflow count", count, 16);
    checkOutput("overflow full", full, 1);
    checkOutput("overflow err_overflow", errOverflow, ERR);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      tick();
      checkOutput($sformatf("drain frame %0d", k), frameOut, mkFrame(k));
      tick();
      checkOutput($sformatf("drain restore %0d", k), restore, 1);
      applyStimulus(1'b0, 1'b1, '0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("drain empty", empty, 1);
    checkOutput("drain count", count, 0);

    $display("[TB] underflow and clr_err");
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("underflow busy", busy, 0);
    checkOutput("underflow err_underflow", errUnderflow, ERR);
    checkOutput("underflow count", count, 0);
    tick();
    checkOutput("underflow restore +1", restore, 0);
    tick();
    checkOutput("underflow restore +2", restore, 0);
    checkOutput("underflow frame_out held", frameOut, mkFrame(0));
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("clr err_overflow", errOverflow, 0);
    checkOutput("clr err_underflow", errUnderflow, 0);
    applyStimulus(1'b0, 1'b1, '0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("set beats clr", errUnderflow, ERR);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("second clr", errUnderflow, 0);

    $display("[TB] busy and simultaneous requests");
    applyStimulus(1'b1, 1'b0, f0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, f1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, mkFrame(30), 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("push during busy count", count, 1);
    tick();
    checkOutput("busy pop restore", restore, 1);
    checkOutput("busy pop frame", frameOut, f1);
    applyStimulus(1'b1, 1'b1, mkFrame(31), 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("both count", count, 1);
    checkOutput("both busy", busy, 0);
    tick();
    tick();
    checkOutput("both restore", restore, 0);
    checkOutput("both err_overflow", errOverflow, 0);
    checkOutput("both err_underflow", errUnderflow, 0);

    $display("[TB] reset during LOAD");
    applyStimulus(1'b1, 1'b0, mkFrame(20), 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, mkFrame(21), 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("pre-reset count", count, 3);
    applyStimulus(1'b0, 1'b1, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("pre-reset busy", busy, 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("mid-pop reset frame_out", frameOut, '0);
    checkOutput("mid-pop reset busy", busy, 0);
    checkOutput("mid-pop reset count", count, 0);
    checkOutput("mid-pop reset empty", empty, 1);
    checkOutput("mid-pop reset restore", restore, 0);
    #4 resetN = 1'b1;
    tick();
    checkOutput("post-reset restore +1", restore, 0);
    tick();
    checkOutput("post-reset restore +2", restore, 0);
    tick();
    checkOutput("post-reset restore +3", restore, 0);
    checkOutput("post-reset frame_out", frameOut, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
